// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: holds the program counter (PC) and instruction register (IR) for
// the control unit. It executes the PC_CLR / PR_ID / PC_IC / PC_LD commands
// and fetches instructions from instruction memory over a request/response
// handshake whose latency can vary.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   PC_CLR       in   clear PC to 0; aborts any fetch in flight
//   PR_ID        in   fetch mem[PC] into IR (ignored while FETCH_BUSY=1)
//   PC_IC        in   increment PC (wraps modulo 2^ADDR_W)
//   PC_LD        in   load PC from PC_LD_ADDR (jump)
//   PC_LD_ADDR   in   jump target
//   IM_REQ       out  memory read request, one-cycle pulse
//   IM_ADDR      out  read address, valid while IM_REQ=1 (held otherwise)
//   IM_RVALID    in   read data valid, one cycle per request
//   IM_RDATA     in   read data
//   IR           out  instruction register
//   PC           out  program counter
//   IR_VALID     out  one-cycle pulse when IR has just been updated
//   FETCH_BUSY   out  a fetch is outstanding
//   FETCH_FAULT  out  sticky fetch-timeout flag
//
// Build option: define IFU_FAULT_EN to add the fetch timeout counter. When
// it is undefined, WAIT/DISCARD wait forever and FETCH_FAULT is tied to 0.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PC_CLR,
  input  logic               PR_ID,
  input  logic               PC_IC,
  input  logic               PC_LD,
  input  logic [ADDR_W-1:0]  PC_LD_ADDR,
  output logic               IM_REQ,
  output logic [ADDR_W-1:0]  IM_ADDR,
  input  logic               IM_RVALID,
  input  logic [INSTR_W-1:0] IM_RDATA,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  PC,
  output logic               IR_VALID,
  output logic               FETCH_BUSY,
  output logic               FETCH_FAULT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    im_addr_q, im_addr_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 im_req_q, im_req_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 busy_q, busy_d;
  logic                 timeout_hit;

`ifdef IFU_FAULT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // The counter value equals the number of completed WAIT/DISCARD cycles.
  // Hitting TIMEOUT-1 with no response in the current cycle means the
  // TIMEOUT-th waiting cycle is ending empty-handed.
  assign timeout_hit = ((state_q == S_WAIT) || (state_q == S_DISCARD)) &&
                       !IM_RVALID &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q | timeout_hit;
    if ((state_q == S_WAIT) || (state_q == S_DISCARD)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_d == S_REQ) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign FETCH_FAULT = fault_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign FETCH_FAULT    = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Next-state / datapath logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    im_addr_d  = im_addr_q;
    ir_d       = ir_q;
    im_req_d   = 1'b0;
    ir_valid_d = 1'b0;

    // PC commands apply in every state; the fetch path latches its own
    // address so in-flight requests are unaffected.
    if (PC_CLR) begin
      pc_d = '0;
    end else if (PC_LD) begin
      pc_d = PC_LD_ADDR;
    end else if (PC_IC) begin
      pc_d = pc_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // Unsolicited IM_RVALID is ignored here.
        if (PR_ID) begin
          state_d   = S_REQ;
          im_req_d  = 1'b1;
          // Address is the PC before this cycle's update, except that a
          // simultaneous clear fetches from address 0.
          im_addr_d = PC_CLR ? '0 : pc_q;
        end
      end

      S_REQ, S_WAIT: begin
        // REQ also accepts a response so zero-latency memories work.
        if (IM_RVALID) begin
          state_d = S_IDLE;
          if (!PC_CLR) begin
            ir_d       = IM_RDATA;
            ir_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d    = S_IDLE;
          ir_d       = '0;
          ir_valid_d = 1'b1;
        end else if (PC_CLR) begin
          state_d = S_DISCARD;
        end else if (state_q == S_REQ) begin
          state_d = S_WAIT;
        end
      end

      S_DISCARD: begin
        if (IM_RVALID) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d    = S_IDLE;
          ir_d       = '0;
          ir_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      im_addr_q  <= '0;
      ir_q       <= '0;
      im_req_q   <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      im_addr_q  <= im_addr_d;
      ir_q       <= ir_d;
      im_req_q   <= im_req_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign IM_REQ     = im_req_q;
  assign IM_ADDR    = im_addr_q;
  assign IR         = ir_q;
  assign PC         = pc_q;
  assign IR_VALID   = ir_valid_q;
  assign FETCH_BUSY = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A bench-side memory responder answers
// each IM_REQ after a programmable latency. A transaction-level model tracks
// each fetch as (request cycle, address, cancelled) and predicts every output
// on every cycle; literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 16;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               PC_CLR, PR_ID, PC_IC, PC_LD;
  logic [ADDR_W-1:0]  PC_LD_ADDR;
  logic               IM_REQ;
  logic [ADDR_W-1:0]  IM_ADDR;
  logic               IM_RVALID;
  logic [INSTR_W-1:0] IM_RDATA;
  logic [INSTR_W-1:0] IR;
  logic [ADDR_W-1:0]  PC;
  logic               IR_VALID, FETCH_BUSY, FETCH_FAULT;

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PC_CLR     (PC_CLR),
    .PR_ID      (PR_ID),
    .PC_IC      (PC_IC),
    .PC_LD      (PC_LD),
    .PC_LD_ADDR (PC_LD_ADDR),
    .IM_REQ     (IM_REQ),
    .IM_ADDR    (IM_ADDR),
    .IM_RVALID  (IM_RVALID),
    .IM_RDATA   (IM_RDATA),
    .IR         (IR),
    .PC         (PC),
    .IR_VALID   (IR_VALID),
    .FETCH_BUSY (FETCH_BUSY),
    .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 Clock = ~Clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Memory contents and responder state.
  logic [15:0] mem [256];
  int          lat  = 2;
  bit          mute = 1'b0;
  int          pend_due[$];
  logic [15:0] pend_data[$];

  // Transaction-level model.
  logic [7:0]  m_pc, m_addr;
  logic [15:0] m_ir;
  bit          f_active, f_cancel, m_fault;
  int          f_req_cycle, m_valid_cycle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc          = 8'h00;
    m_addr        = 8'h00;
    m_ir          = 16'h0000;
    f_active      = 1'b0;
    f_cancel      = 1'b0;
    m_fault       = 1'b0;
    f_req_cycle   = -100;
    m_valid_cycle = -100;
  endtask

  // Apply the rules to this cycle's inputs; predicts the next cycle.
  task automatic model_edge();
    logic [7:0] next_pc;
    int n;
    n = cyc;
    if (PC_CLR)      next_pc = 8'h00;
    else if (PC_LD)  next_pc = PC_LD_ADDR;
    else if (PC_IC)  next_pc = 8'(m_pc + 8'd1);
    else             next_pc = m_pc;

    if (!f_active) begin
      if (PR_ID) begin
        f_active    = 1'b1;
        f_cancel    = 1'b0;
        f_req_cycle = n + 1;
        m_addr      = PC_CLR ? 8'h00 : m_pc;
      end
    end else begin
      if (PC_CLR) f_cancel = 1'b1;
      if (IM_RVALID) begin
        f_active = 1'b0;
        if (!f_cancel) begin
          m_ir          = mem[m_addr];
          m_valid_cycle = n + 1;
        end
      end
`ifdef IFU_FAULT_EN
      else if (n == f_req_cycle + TIMEOUT) begin
        f_active      = 1'b0;
        m_fault       = 1'b1;
        m_ir          = 16'h0000;
        m_valid_cycle = n + 1;
      end
`endif
    end
    m_pc = next_pc;
  endtask

  task automatic compare();
    chk("PC",          32'(PC),          32'(m_pc));
    chk("IR",          32'(IR),          32'(m_ir));
    chk("IM_REQ",      32'(IM_REQ),      32'(f_active && (f_req_cycle == cyc)));
    chk("IM_ADDR",     32'(IM_ADDR),     32'(m_addr));
    chk("IR_VALID",    32'(IR_VALID),    32'(m_valid_cycle == cyc));
    chk("FETCH_BUSY",  32'(FETCH_BUSY),  32'(f_active));
    chk("FETCH_FAULT", 32'(FETCH_FAULT), 32'(m_fault));
  endtask

  // Memory side: latch each request, answer it lat cycles later.
  task automatic respond();
    if (IM_REQ && !mute) begin
      pend_due.push_back(cyc + lat);
      pend_data.push_back(mem[IM_ADDR]);
    end
    IM_RVALID = 1'b0;
    IM_RDATA  = 16'h0000;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      IM_RVALID = 1'b1;
      IM_RDATA  = pend_data[0];
      $display("mem resp cyc=%0d data=%h", cyc, pend_data[0]);
      void'(pend_due.pop_front());
      void'(pend_data.pop_front());
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clock);
    #1;
    cyc++;
    compare();
    PR_ID  = 1'b0;
    PC_IC  = 1'b0;
    PC_LD  = 1'b0;
    PC_CLR = 1'b0;
    respond();
  endtask

  task automatic chk_reset_lits();
    chk("rst_PC",       32'(PC),          32'h0);
    chk("rst_IR",       32'(IR),          32'h0);
    chk("rst_IM_REQ",   32'(IM_REQ),      32'h0);
    chk("rst_IM_ADDR",  32'(IM_ADDR),     32'h0);
    chk("rst_IR_VALID", 32'(IR_VALID),    32'h0);
    chk("rst_BUSY",     32'(FETCH_BUSY),  32'h0);
    chk("rst_FAULT",    32'(FETCH_FAULT), 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    Reset     = 1'b1;
    IM_RVALID = 1'b0;
    #1;
    chk_reset_lits();
    model_reset();
    pend_due.delete();
    pend_data.delete();
    @(posedge Clock);
    #1;
    cyc++;
    Reset = 1'b0;
    compare();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
    mem[0]     = 16'h1234;
    mem[5]     = 16'hA5A5;
    mem[8'h20] = 16'hBEEF;

    Reset = 1'b1;
    PC_CLR = 1'b0; PR_ID = 1'b0; PC_IC = 1'b0; PC_LD = 1'b0;
    PC_LD_ADDR = 8'h00; IM_RVALID = 1'b0; IM_RDATA = 16'h0000;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk_reset_lits();
    Reset = 1'b0;
    cyc = 0;
    compare();

    // Basic fetch, L=2.
    lat = 2;
    PR_ID = 1'b1; tick();
    chk("A_req",   32'(IM_REQ),     32'h1);
    chk("A_addr",  32'(IM_ADDR),    32'h0);
    chk("A_busy1", 32'(FETCH_BUSY), 32'h1);
    tick(); chk("A_busy2", 32'(FETCH_BUSY), 32'h1);
    tick(); chk("A_busy3", 32'(FETCH_BUSY), 32'h1);
    tick();
    chk("A_ir",    32'(IR),         32'h1234);
    chk("A_valid", 32'(IR_VALID),   32'h1);
    chk("A_busy4", 32'(FETCH_BUSY), 32'h0);

    // PC wrap and command priority.
    PC_LD = 1'b1; PC_LD_ADDR = 8'hFF; tick(); chk("B_ld",   32'(PC), 32'hFF);
    PC_IC = 1'b1; tick();                      chk("B_wrap", 32'(PC), 32'h00);
    PC_LD = 1'b1; PC_LD_ADDR = 8'h40; PC_IC = 1'b1; tick();
    chk("B_prio", 32'(PC), 32'h40);

    // Fetch with same-cycle increment; PR_ID while busy is ignored.
    lat = 3;
    PC_LD = 1'b1; PC_LD_ADDR = 8'h05; tick();
    PR_ID = 1'b1; PC_IC = 1'b1; tick();
    chk("C_req",  32'(IM_REQ),  32'h1);
    chk("C_addr", 32'(IM_ADDR), 32'h05);
    chk("C_pc",   32'(PC),      32'h06);
    PR_ID = 1'b1; PC_IC = 1'b1; tick();
    chk("C_noreq", 32'(IM_REQ), 32'h0);
    chk("C_pc2",   32'(PC),     32'h07);
    PR_ID = 1'b1; tick();
    tick();
    tick();
    chk("C_ir",    32'(IR),       32'hA5A5);
    chk("C_valid", 32'(IR_VALID), 32'h1);

    // PC_CLR during WAIT discards the response.
    PC_LD = 1'b1; PC_LD_ADDR = 8'h20; tick();
    PR_ID = 1'b1; tick();
    tick();
    PC_CLR = 1'b1; tick();
    chk("D_pc",    32'(PC),         32'h0);
    chk("D_busy",  32'(FETCH_BUSY), 32'h1);
    tick();
    chk("D_busy2", 32'(FETCH_BUSY), 32'h1);
    tick();
    chk("D_busy3", 32'(FETCH_BUSY), 32'h0);
    chk("D_ir",    32'(IR),         32'hA5A5);
    chk("D_valid", 32'(IR_VALID),   32'h0);

    // Zero-latency memory: IR two cycles after PR_ID.
    lat = 0;
    PC_LD = 1'b1; PC_LD_ADDR = 8'h33; tick();
    PR_ID = 1'b1; tick();
    tick();
    chk("E_ir",    32'(IR),       32'h33CC);
    chk("E_valid", 32'(IR_VALID), 32'h1);

    // PC_CLR with PR_ID in IDLE fetches address 0.
    lat = 1;
    PC_CLR = 1'b1; PR_ID = 1'b1; tick();
    chk("F_addr", 32'(IM_ADDR), 32'h0);
    chk("F_pc",   32'(PC),      32'h0);
    chk("F_req",  32'(IM_REQ),  32'h1);
    tick();
    tick();
    chk("F_ir", 32'(IR), 32'h1234);

    // Unsolicited response in IDLE.
    IM_RVALID = 1'b1; IM_RDATA = 16'hDEAD; tick();
    chk("G_ir",    32'(IR),       32'h1234);
    chk("G_valid", 32'(IR_VALID), 32'h0);

    // PC_CLR in the same cycle as the response.
    lat = 2;
    PC_LD = 1'b1; PC_LD_ADDR = 8'h05; tick();
    PR_ID = 1'b1; tick();
    tick();
    tick();
    chk("H_rv", 32'(IM_RVALID), 32'h1);
    PC_CLR = 1'b1; tick();
    chk("H_busy",  32'(FETCH_BUSY), 32'h0);
    chk("H_valid", 32'(IR_VALID),   32'h0);
    chk("H_ir",    32'(IR),         32'h1234);

    // Reset during WAIT; next fetch goes to address 0.
    PC_LD = 1'b1; PC_LD_ADDR = 8'h10; tick();
    PR_ID = 1'b1; tick();
    tick();
    do_reset();
    lat = 1;
    PR_ID = 1'b1; tick();
    chk("I_req",  32'(IM_REQ),  32'h1);
    chk("I_addr", 32'(IM_ADDR), 32'h0);
    tick();
    tick();
    chk("I_ir", 32'(IR), 32'h1234);

`ifdef IFU_FAULT_EN
    // No response: timeout 16 cycles after WAIT entry.
    mute = 1'b1;
    PR_ID = 1'b1; tick();
    repeat (16) tick();
    chk("J_nofault", 32'(FETCH_FAULT), 32'h0);
    tick();
    chk("J_fault", 32'(FETCH_FAULT), 32'h1);
    chk("J_ir",    32'(IR),          32'h0);
    chk("J_valid", 32'(IR_VALID),    32'h1);
    mute = 1'b0;
    PR_ID = 1'b1; tick();
    tick();
    tick();
    chk("J_ir2",    32'(IR),          32'h1234);
    chk("J_fault2", 32'(FETCH_FAULT), 32'h1);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the control unit. Holds the program counter (PC) and instruction register (IR) and executes the control unit's PC_CLR / PR_ID / PC_IC commands. Fetches from instruction memory over a request/response handshake with variable latency. Presents IR to the control unit's decoder and PC to debug/trace.

Parameters:
ADDR_W, 8, PC and instruction memory address width
INSTR_W, 16, instruction width
TIMEOUT, 16, fetch timeout in cycles (used only with IFU_FAULT_EN)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
PC_CLR  in  1  clear PC to 0; aborts any fetch in flight
PR_ID  in  1  load command: fetch mem[PC] into IR
PC_IC  in  1  increment PC
PC_LD  in  1  load PC from PC_LD_ADDR (jump)
PC_LD_ADDR  in  ADDR_W  jump target
IM_REQ  out  1  memory read request, one-cycle pulse
IM_ADDR  out  ADDR_W  read address, valid while IM_REQ=1
IM_RVALID  in  1  read data valid, one cycle per request
IM_RDATA  in  INSTR_W  read data
IR  out  INSTR_W  instruction register
PC  out  ADDR_W  program counter
IR_VALID  out  1  one-cycle pulse when IR has just been updated
FETCH_BUSY  out  1  a fetch is outstanding
FETCH_FAULT  out  1  sticky timeout flag (IFU_FAULT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async): PC=0, IR=16'h0000, IM_REQ=0, IM_ADDR=0, IR_VALID=0, FETCH_BUSY=0, FETCH_FAULT=0, state=IDLE.
- All outputs are registered.
- PC update priority, evaluated every cycle in all states: PC_CLR > PC_LD > PC_IC.
  - PC_IC: PC <= PC+1 modulo 2^ADDR_W (8'hFF -> 8'h00).
- FSM states: IDLE, REQ, WAIT, DISCARD.
  - IDLE: PR_ID=1 -> REQ. IM_ADDR <= current PC value, before any same-cycle PC_IC/PC_LD takes effect.
  - REQ: IM_REQ=1 for exactly this cycle -> WAIT. FETCH_BUSY=1 in REQ, WAIT and DISCARD.
  - WAIT: IM_RVALID=1 -> IR <= IM_RDATA, next cycle IR_VALID=1, -> IDLE.
  - DISCARD: IM_RVALID=1 -> response dropped, IR unchanged, no IR_VALID, -> IDLE.
- Latency: with memory latency L (IM_RVALID L cycles after IM_REQ):
  - PR_ID at cycle 0 -> IM_REQ at cycle 1 -> IR updated and IR_VALID at cycle 2+L.
  - Minimum is cycle 2 for L=0, i.e. IM_RVALID in the same cycle as IM_REQ; REQ then goes straight to the WAIT-capture path.
- PR_ID while FETCH_BUSY=1 is ignored. The control unit must wait for IR_VALID.
- PC_IC/PC_LD during REQ/WAIT change PC only. The in-flight fetch keeps its latched address.
- PC_CLR in REQ or WAIT: PC <= 0, state -> DISCARD. An IM_RVALID arriving in the same cycle as PC_CLR is also discarded.
- PC_CLR and PR_ID in the same IDLE cycle: PC cleared and fetch issued to address 0.
- IM_RVALID in IDLE (unsolicited) is ignored.
- IR holds its value indefinitely between fetches.

Optional Feature:
Macro IFU_FAULT_EN.
- Defined:
  - A counter runs in WAIT and DISCARD and is cleared on entry to REQ.
  - When it reaches TIMEOUT with no IM_RVALID: FETCH_FAULT <= 1 (sticky until Reset), IR <= 16'h0000, IR_VALID pulses, state -> IDLE.
  - Any late response is then ignored as unsolicited.
- Undefined: no counter; WAIT/DISCARD wait forever; FETCH_FAULT is constant 0.

Test Plan:
- Reset mid-WAIT -> all outputs at reset values in the same cycle (async); the next PR_ID fetches address 0.
- mem[0]=16'h1234, L=2, PR_ID at cycle 0 -> IM_REQ=1 with IM_ADDR=0 at cycle 1; IR=16'h1234 and IR_VALID=1 at cycle 4; FETCH_BUSY=1 at cycles 1-3.
- PC=8'hFF, PC_IC=1 -> PC=8'h00. PC_LD=1 with PC_LD_ADDR=8'h40 and PC_IC=1 in the same cycle -> PC=8'h40.
- PR_ID with PC=5 and PC_IC in the same cycle -> IM_ADDR=5, PC=6. A second PR_ID during WAIT -> no second IM_REQ.
- PC_CLR during WAIT (L=3), response 16'hBEEF -> IR unchanged, no IR_VALID, PC=0, FETCH_BUSY drops the cycle after IM_RVALID.
- IFU_FAULT_EN, TIMEOUT=16, IM_RVALID never asserted -> FETCH_FAULT=1, IR=0 and IR_VALID pulse 16 cycles after WAIT entry; the next PR_ID fetches normally.
